nand_async_cmd_seq: RTL and testbench

Upstream sequencer that drives the controller-facing pins of the NAND PHY in ONFI asynchronous mode.
- Accepts one request: command byte, 0-5 address bytes, 0-15 read bytes.
- Generates CE#/CLE/ALE/WE#/RE# timing in v_clk0 cycles, drives DQ write data, and returns captured read bytes.
- Used for RESET, READ ID, READ STATUS, GET/SET FEATURES-style bring-up before sync mode.

---
 rtl/nand_async_pkg.sv | 37 +++
 rtl/nand_async_phase_timer.sv | 27 ++
 rtl/nand_async_cmd_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_nand_async_cmd_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_async_pkg.sv
// Shared types and constants for the ONFI asynchronous-mode command sequencer.
package nand_async_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CE_SETUP,
        ST_CMD_LO,
        ST_CMD_HI,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_WHR_WAIT,
        ST_RD_LO,
        ST_RD_HI,
        ST_CE_HOLD
    } state_t;

    localparam int DEF_TCS_CYC  = 2;
    localparam int DEF_TWP_CYC  = 3;
    localparam int DEF_TWH_CYC  = 2;
    localparam int DEF_TWHR_CYC = 8;
    localparam int DEF_TRP_CYC  = 3;
    localparam int DEF_TREH_CYC = 2;
    localparam int DEF_TCH_CYC  = 2;

    localparam logic [7:0] OP_RESET        = 8'hFF;
    localparam logic [7:0] OP_READ_ID      = 8'h90;
    localparam logic [7:0] OP_READ_STATUS  = 8'h70;
    localparam logic [7:0] OP_SET_FEATURES = 8'hEF;
    localparam logic [7:0] OP_GET_FEATURES = 8'hEE;

    localparam int MAX_ADDR_BYTES = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nand_async_phase_timer.sv
// Down-counting phase timer: expire is high during the last cycle of a phase.
module nand_async_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // A zero-length phase is stretched to one cycle so every state is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= W'(1);
        end else if (load) begin
            cnt <= (load_val == '0) ? W'(1) : load_val;
        end else if (cnt > W'(1)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt <= W'(1));

endmodule

// File: rtl/nand_async_cmd_seq.sv
// ONFI async-mode sequencer: one command, up to five address bytes, up to fifteen read bytes.
module nand_async_cmd_seq
    import nand_async_pkg::*;
#(
    parameter int TCS_CYC  = DEF_TCS_CYC,
    parameter int TWP_CYC  = DEF_TWP_CYC,
    parameter int TWH_CYC  = DEF_TWH_CYC,
    parameter int TWHR_CYC = DEF_TWHR_CYC,
    parameter int TRP_CYC  = DEF_TRP_CYC,
    parameter int TREH_CYC = DEF_TREH_CYC,
    parameter int TCH_CYC  = DEF_TCH_CYC
) (
    input  logic        v_clk0,
    input  logic        v_rstn0,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [2:0]  req_naddr,
    input  logic [39:0] req_addr,
    input  logic [3:0]  req_nrd,
    input  logic [2:0]  req_ce,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic [7:0]  v_ctrl_cen,
    output logic        v_ctrl_cle,
    output logic        v_ctrl_ale,
    output logic        v_ctrl_wrn,
    output logic        v_ctrl_wpn,
    output logic        v_ctrl_wen,
    output logic        v_ctrl_wen_sel,
    output logic        v_dq_oe_n,
    output logic        v_dqs_oe_n,
    output logic [7:0]  v_wr_data_rise,
    output logic [7:0]  v_wr_data_fall,
    input  logic [7:0]  v_rd_data_comb
);

    localparam int MAX_CYC = max_int(max_int(max_int(TCS_CYC, TWP_CYC), max_int(TWH_CYC, TWHR_CYC)),
                                     max_int(max_int(TRP_CYC, TREH_CYC), max_int(TCH_CYC, 1)));
    localparam int TW = $clog2(MAX_CYC + 1);

    state_t        state, next_state;
    logic          expire;
    logic          accept;
    logic          timer_load;
    logic [TW-1:0] timer_val;

    logic [7:0]  cmd_q;
    logic [2:0]  naddr_q;
    logic [39:0] addr_q;
    logic [3:0]  nrd_q;
    logic [2:0]  ce_q;
    logic [2:0]  addr_done;
    logic [3:0]  rd_done;

    logic [7:0]  cen_d;
    logic        cle_d, ale_d, wen_d, wrn_d, dq_oe_n_d;
    logic [7:0]  wr_data_d;
    logic [2:0]  ce_sel;
    logic [39:0] addr_shift;

    assign accept = (state == ST_IDLE) && req_valid;

    always_ff @(posedge v_clk0 or negedge v_rstn0) begin
        if (!v_rstn0) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (req_valid) next_state = ST_CE_SETUP;
            ST_CE_SETUP: if (expire) next_state = ST_CMD_LO;
            ST_CMD_LO:   if (expire) next_state = ST_CMD_HI;
            ST_CMD_HI: begin
                if (expire) begin
                    if (naddr_q != 3'd0)    next_state = ST_ADDR_LO;
                    else if (nrd_q != 4'd0) next_state = ST_WHR_WAIT;
                    else                    next_state = ST_CE_HOLD;
                end
            end
            ST_ADDR_LO:  if (expire) next_state = ST_ADDR_HI;
            ST_ADDR_HI: begin
                if (expire) begin
                    if (addr_done < naddr_q) next_state = ST_ADDR_LO;
                    else if (nrd_q != 4'd0)  next_state = ST_WHR_WAIT;
                    else                     next_state = ST_CE_HOLD;
                end
            end
            ST_WHR_WAIT: if (expire) next_state = ST_RD_LO;
            ST_RD_LO:    if (expire) next_state = ST_RD_HI;
            ST_RD_HI: begin
                if (expire) next_state = (rd_done < nrd_q) ? ST_RD_LO : ST_CE_HOLD;
            end
            ST_CE_HOLD:  if (expire) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // The timer is reloaded on every state change with the length of the phase being entered.
    always_comb begin
        timer_load = (next_state != state);
        timer_val  = TW'(1);
        case (next_state)
            ST_CE_SETUP: timer_val = TW'(TCS_CYC);
            ST_CMD_LO:   timer_val = TW'(TWP_CYC);
            ST_CMD_HI:   timer_val = TW'(TWH_CYC);
            ST_ADDR_LO:  timer_val = TW'(TWP_CYC);
            ST_ADDR_HI:  timer_val = TW'(TWH_CYC);
            ST_WHR_WAIT: timer_val = TW'(TWHR_CYC);
            ST_RD_LO:    timer_val = TW'(TRP_CYC);
            ST_RD_HI:    timer_val = TW'(TREH_CYC);
            ST_CE_HOLD:  timer_val = TW'(TCH_CYC);
            default:     timer_val = TW'(1);
        endcase
    end

    nand_async_phase_timer #(.W(TW)) u_timer (
        .clk      (v_clk0),
        .rst_n    (v_rstn0),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (expire)
    );

    always_ff @(posedge v_clk0 or negedge v_rstn0) begin
        if (!v_rstn0) begin
            cmd_q     <= '0;
            naddr_q   <= '0;
            addr_q    <= '0;
            nrd_q     <= '0;
            ce_q      <= '0;
            addr_done <= '0;
            rd_done   <= '0;
        end else if (accept) begin
            cmd_q     <= req_cmd;
            naddr_q   <= (req_naddr > 3'(MAX_ADDR_BYTES)) ? 3'(MAX_ADDR_BYTES) : req_naddr;
            addr_q    <= req_addr;
            nrd_q     <= req_nrd;
            ce_q      <= req_ce;
            addr_done <= '0;
            rd_done   <= '0;
        end else begin
            if (state == ST_ADDR_LO && expire) addr_done <= addr_done + 3'd1;
            if (state == ST_RD_LO && expire)   rd_done   <= rd_done + 4'd1;
        end
    end

    // Outputs are decoded from next_state and registered, so pins change together with the state.
    // On the accepting edge the request registers are not loaded yet, hence the bypass.
    assign ce_sel     = accept ? req_ce : ce_q;
    assign addr_shift = addr_q >> {addr_done, 3'b000};

    always_comb begin
        cen_d     = 8'hFF;
        cle_d     = 1'b0;
        ale_d     = 1'b0;
        wen_d     = 1'b1;
        wrn_d     = 1'b1;
        dq_oe_n_d = 1'b1;
        wr_data_d = v_wr_data_rise;
        case (next_state)
            ST_CE_SETUP: begin
                cle_d     = 1'b1;
                dq_oe_n_d = 1'b0;
                wr_data_d = accept ? req_cmd : cmd_q;
            end
            ST_CMD_LO: begin
                cle_d     = 1'b1;
                wen_d     = 1'b0;
                dq_oe_n_d = 1'b0;
            end
            ST_CMD_HI: begin
                cle_d     = 1'b1;
                dq_oe_n_d = 1'b0;
            end
            ST_ADDR_LO: begin
                ale_d     = 1'b1;
                wen_d     = 1'b0;
                dq_oe_n_d = 1'b0;
                wr_data_d = addr_shift[7:0];
            end
            ST_ADDR_HI: begin
                ale_d     = 1'b1;
                dq_oe_n_d = 1'b0;
            end
            ST_RD_LO:    wrn_d = 1'b0;
            default:     ;
        endcase
        if (next_state != ST_IDLE) cen_d = ~(8'h01 << ce_sel);
    end

    always_ff @(posedge v_clk0 or negedge v_rstn0) begin
        if (!v_rstn0) begin
            v_ctrl_cen     <= 8'hFF;
            v_ctrl_cle     <= 1'b0;
            v_ctrl_ale     <= 1'b0;
            v_ctrl_wrn     <= 1'b1;
            v_ctrl_wpn     <= 1'b0;
            v_ctrl_wen     <= 1'b1;
            v_dq_oe_n      <= 1'b1;
            v_wr_data_rise <= 8'h00;
            rd_data        <= 8'h00;
            rd_valid       <= 1'b0;
            done           <= 1'b0;
            req_ready      <= 1'b1;
        end else begin
            v_ctrl_cen     <= cen_d;
            v_ctrl_cle     <= cle_d;
            v_ctrl_ale     <= ale_d;
            v_ctrl_wrn     <= wrn_d;
            v_ctrl_wpn     <= 1'b1;
            v_ctrl_wen     <= wen_d;
            v_dq_oe_n      <= dq_oe_n_d;
            v_wr_data_rise <= wr_data_d;
            rd_valid       <= (state == ST_RD_LO) && expire;
            done           <= (state == ST_CE_HOLD) && expire;
            req_ready      <= (next_state == ST_IDLE);
            if ((state == ST_RD_LO) && expire) rd_data <= v_rd_data_comb;
        end
    end

    assign v_wr_data_fall = v_wr_data_rise;
    assign v_ctrl_wen_sel = 1'b1;
    assign v_dqs_oe_n     = 1'b1;

endmodule

// File: tb/tb_nand_async_cmd_seq.sv
// Directed bench for nand_async_cmd_seq with default timing and a tiny PHY read-data model.
module tb_nand_async_cmd_seq;
    import nand_async_pkg::*;

    logic        v_clk0 = 1'b0;
    logic        v_rstn0 = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = 8'h00;
    logic [2:0]  req_naddr = 3'd0;
    logic [39:0] req_addr = 40'h0;
    logic [3:0]  req_nrd = 4'd0;
    logic [2:0]  req_ce = 3'd0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic [7:0]  v_ctrl_cen;
    logic        v_ctrl_cle, v_ctrl_ale, v_ctrl_wrn, v_ctrl_wpn, v_ctrl_wen, v_ctrl_wen_sel;
    logic        v_dq_oe_n, v_dqs_oe_n;
    logic [7:0]  v_wr_data_rise, v_wr_data_fall;
    logic [7:0]  v_rd_data_comb = 8'h00;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] cen_log [0:63];
    logic [7:0] wr_log  [0:63];
    logic [7:0] rdd_log [0:63];
    logic       cle_log [0:63];
    logic       ale_log [0:63];
    logic       wen_log [0:63];
    logic       wrn_log [0:63];
    logic       dqoe_log[0:63];
    logic       rdv_log [0:63];
    logic       done_log[0:63];
    logic       rdy_log [0:63];

    logic [7:0] phy_bytes [0:3];
    int         re_cnt = 0;

    nand_async_cmd_seq dut (
        .v_clk0         (v_clk0),
        .v_rstn0        (v_rstn0),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cmd        (req_cmd),
        .req_naddr      (req_naddr),
        .req_addr       (req_addr),
        .req_nrd        (req_nrd),
        .req_ce         (req_ce),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .done           (done),
        .v_ctrl_cen     (v_ctrl_cen),
        .v_ctrl_cle     (v_ctrl_cle),
        .v_ctrl_ale     (v_ctrl_ale),
        .v_ctrl_wrn     (v_ctrl_wrn),
        .v_ctrl_wpn     (v_ctrl_wpn),
        .v_ctrl_wen     (v_ctrl_wen),
        .v_ctrl_wen_sel (v_ctrl_wen_sel),
        .v_dq_oe_n      (v_dq_oe_n),
        .v_dqs_oe_n     (v_dqs_oe_n),
        .v_wr_data_rise (v_wr_data_rise),
        .v_wr_data_fall (v_wr_data_fall),
        .v_rd_data_comb (v_rd_data_comb)
    );

    always #5 v_clk0 = ~v_clk0;

    // PHY model: each RE# fall presents the next byte of the device response.
    always @(negedge v_ctrl_wrn) begin
        v_rd_data_comb = phy_bytes[re_cnt];
        re_cnt = (re_cnt + 1) % 4;
    end

    task automatic tick();
        @(posedge v_clk0);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sampleInto(input int i);
        cen_log[i]  = v_ctrl_cen;
        cle_log[i]  = v_ctrl_cle;
        ale_log[i]  = v_ctrl_ale;
        wen_log[i]  = v_ctrl_wen;
        wrn_log[i]  = v_ctrl_wrn;
        dqoe_log[i] = v_dq_oe_n;
        wr_log[i]   = v_wr_data_rise;
        rdv_log[i]  = rd_valid;
        rdd_log[i]  = rd_data;
        done_log[i] = done;
        rdy_log[i]  = req_ready;
    endtask

    task automatic captureCycles(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            tick();
            sampleInto(i);
        end
    endtask

    // Presents a request in the current (idle) cycle; log index 1 is the first cycle after acceptance.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [2:0] naddr, input logic [39:0] addr,
                                 input logic [3:0] nrd, input logic [2:0] ce, input bit hold);
        req_cmd   = cmd;
        req_naddr = naddr;
        req_addr  = addr;
        req_nrd   = nrd;
        req_ce    = ce;
        req_valid = 1'b1;
        tick();
        sampleInto(1);
        if (!hold) req_valid = 1'b0;
    endtask

    function automatic bit inr(input int i, input int a, input int b);
        return (i >= a) && (i <= b);
    endfunction

    initial begin
        int pulses;
        int early_done;
        logic [7:0] exp_addr [0:4];

        phy_bytes[0] = 8'h2C;
        phy_bytes[1] = 8'h88;
        phy_bytes[2] = 8'h04;
        phy_bytes[3] = 8'h4B;

        // Reset values while reset is asserted
        #2 v_rstn0 = 1'b0;
        #1;
        checkOutput("rst_cen", v_ctrl_cen, 8'hFF);
        checkOutput("rst_cle", v_ctrl_cle, 1'b0);
        checkOutput("rst_ale", v_ctrl_ale, 1'b0);
        checkOutput("rst_wrn", v_ctrl_wrn, 1'b1);
        checkOutput("rst_wpn", v_ctrl_wpn, 1'b0);
        checkOutput("rst_wen", v_ctrl_wen, 1'b1);
        checkOutput("rst_wen_sel", v_ctrl_wen_sel, 1'b1);
        checkOutput("rst_dq_oe_n", v_dq_oe_n, 1'b1);
        checkOutput("rst_dqs_oe_n", v_dqs_oe_n, 1'b1);
        checkOutput("rst_wr_data", v_wr_data_rise, 8'h00);
        checkOutput("rst_rd_data", rd_data, 8'h00);
        checkOutput("rst_rd_valid", rd_valid, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        tick();
        tick();
        #2 v_rstn0 = 1'b1;
        tick();
        checkOutput("post_rst_ready", req_ready, 1'b1);
        checkOutput("post_rst_wpn", v_ctrl_wpn, 1'b1);

        // RESET opcode: command only
        applyStimulus(OP_RESET, 3'd0, 40'h0, 4'd0, 3'd0, 1'b0);
        captureCycles(2, 10);
        for (int i = 1; i <= 10; i++) begin
            checkOutput($sformatf("reset_cen@%0d", i), cen_log[i], (i <= 9) ? 8'hFE : 8'hFF);
            checkOutput($sformatf("reset_cle@%0d", i), cle_log[i], inr(i, 1, 7));
            checkOutput($sformatf("reset_wen@%0d", i), wen_log[i], !inr(i, 3, 5));
            checkOutput($sformatf("reset_done@%0d", i), done_log[i], (i == 10));
            checkOutput($sformatf("reset_ready@%0d", i), rdy_log[i], (i == 10));
            checkOutput($sformatf("reset_rdv@%0d", i), rdv_log[i], 1'b0);
        end
        checkOutput("reset_wr_data", wr_log[4], 8'hFF);

        // READ ID: one address byte, four read bytes
        applyStimulus(OP_READ_ID, 3'd1, 40'h0, 4'd4, 3'd3, 1'b0);
        captureCycles(2, 43);
        for (int i = 1; i <= 43; i++) begin
            checkOutput($sformatf("rid_cen@%0d", i), cen_log[i], (i <= 42) ? 8'hF7 : 8'hFF);
            checkOutput($sformatf("rid_wen@%0d", i), wen_log[i], !(inr(i, 3, 5) || inr(i, 8, 10)));
            checkOutput($sformatf("rid_wrn@%0d", i), wrn_log[i],
                        !(inr(i, 21, 23) || inr(i, 26, 28) || inr(i, 31, 33) || inr(i, 36, 38)));
            checkOutput($sformatf("rid_rdv@%0d", i), rdv_log[i], (i == 24 || i == 29 || i == 34 || i == 39));
            checkOutput($sformatf("rid_ale@%0d", i), ale_log[i], inr(i, 8, 12));
            checkOutput($sformatf("rid_done@%0d", i), done_log[i], (i == 43));
        end
        checkOutput("rid_byte0", rdd_log[24], 8'h2C);
        checkOutput("rid_byte1", rdd_log[29], 8'h88);
        checkOutput("rid_byte2", rdd_log[34], 8'h04);
        checkOutput("rid_byte3", rdd_log[39], 8'h4B);
        checkOutput("rid_dqoe_whr", dqoe_log[13], 1'b1);

        // Address byte order with five bytes
        exp_addr[0] = 8'h04;
        exp_addr[1] = 8'h03;
        exp_addr[2] = 8'h02;
        exp_addr[3] = 8'h01;
        exp_addr[4] = 8'h00;
        applyStimulus(OP_SET_FEATURES, 3'd5, 40'h00_0102_0304, 4'd0, 3'd1, 1'b0);
        captureCycles(2, 35);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("addr_lo_byte%0d", k), wr_log[8 + 5 * k], exp_addr[k]);
            checkOutput($sformatf("addr_hi_byte%0d", k), wr_log[12 + 5 * k], exp_addr[k]);
            checkOutput($sformatf("addr_wen%0d", k), wen_log[9 + 5 * k], 1'b0);
        end
        for (int i = 1; i <= 35; i++) begin
            checkOutput($sformatf("addr_dqoe@%0d", i), dqoe_log[i], !inr(i, 1, 32));
            checkOutput($sformatf("addr_ale@%0d", i), ale_log[i], inr(i, 8, 32));
            checkOutput($sformatf("addr_cle@%0d", i), cle_log[i], inr(i, 1, 7));
            checkOutput($sformatf("addr_cen@%0d", i), cen_log[i], (i <= 34) ? 8'hFD : 8'hFF);
        end
        checkOutput("addr_done", done_log[35], 1'b1);

        // Address count 7 clamps to 5
        applyStimulus(OP_SET_FEATURES, 3'd7, 40'hAA_BBCC_DDEE, 4'd0, 3'd0, 1'b0);
        captureCycles(2, 36);
        pulses = 0;
        early_done = 0;
        for (int i = 2; i <= 36; i++) begin
            if (!wen_log[i] && wen_log[i - 1] && ale_log[i]) pulses++;
            if (done_log[i] && i != 35) early_done++;
        end
        checkOutput("clamp_ale_pulses", pulses, 5);
        checkOutput("clamp_done", done_log[35], 1'b1);
        checkOutput("clamp_other_done", early_done, 0);
        checkOutput("clamp_last_byte", wr_log[28], 8'hAA);

        // Asynchronous reset in the second ADDR_LO cycle
        applyStimulus(OP_SET_FEATURES, 3'd2, 40'h11_2233_4455, 4'd0, 3'd4, 1'b0);
        captureCycles(2, 9);
        checkOutput("ares_pre_ale", ale_log[9], 1'b1);
        checkOutput("ares_pre_wen", wen_log[9], 1'b0);
        checkOutput("ares_pre_wr", wr_log[9], 8'h55);
        checkOutput("ares_pre_wr_fall", v_wr_data_fall, 8'h55);
        checkOutput("ares_pre_cen", cen_log[9], 8'hEF);
        #2 v_rstn0 = 1'b0;
        #1;
        checkOutput("ares_cen", v_ctrl_cen, 8'hFF);
        checkOutput("ares_ale", v_ctrl_ale, 1'b0);
        checkOutput("ares_wen", v_ctrl_wen, 1'b1);
        checkOutput("ares_wpn", v_ctrl_wpn, 1'b0);
        checkOutput("ares_dqoe", v_dq_oe_n, 1'b1);
        checkOutput("ares_wr", v_wr_data_rise, 8'h00);
        checkOutput("ares_ready", req_ready, 1'b1);
        tick();
        tick();
        #2 v_rstn0 = 1'b1;
        tick();
        tick();
        checkOutput("ares_post_wpn", v_ctrl_wpn, 1'b1);
        checkOutput("ares_post_ready", req_ready, 1'b1);

        // READ STATUS after the reset
        phy_bytes[re_cnt] = 8'hE0;
        applyStimulus(OP_READ_STATUS, 3'd0, 40'h0, 4'd1, 3'd2, 1'b0);
        captureCycles(2, 23);
        for (int i = 1; i <= 23; i++) begin
            checkOutput($sformatf("rs_cen@%0d", i), cen_log[i], (i <= 22) ? 8'hFB : 8'hFF);
            checkOutput($sformatf("rs_wrn@%0d", i), wrn_log[i], !inr(i, 16, 18));
            checkOutput($sformatf("rs_rdv@%0d", i), rdv_log[i], (i == 19));
            checkOutput($sformatf("rs_done@%0d", i), done_log[i], (i == 23));
        end
        checkOutput("rs_status", rdd_log[19], 8'hE0);
        checkOutput("rs_cmd", wr_log[2], 8'h70);

        // Back-to-back with req_valid held high
        applyStimulus(OP_RESET, 3'd0, 40'h0, 4'd0, 3'd0, 1'b1);
        req_cmd = OP_SET_FEATURES;
        req_ce  = 3'd5;
        captureCycles(2, 11);
        req_valid = 1'b0;
        captureCycles(12, 20);
        checkOutput("b2b_first_cmd", wr_log[7], 8'hFF);
        checkOutput("b2b_cen9", cen_log[9], 8'hFE);
        checkOutput("b2b_cen10", cen_log[10], 8'hFF);
        checkOutput("b2b_cen11", cen_log[11], 8'hDF);
        checkOutput("b2b_cen19", cen_log[19], 8'hDF);
        checkOutput("b2b_cen20", cen_log[20], 8'hFF);
        checkOutput("b2b_second_cmd", wr_log[11], 8'hEF);
        for (int i = 1; i <= 20; i++) begin
            checkOutput($sformatf("b2b_done@%0d", i), done_log[i], (i == 10 || i == 20));
            checkOutput($sformatf("b2b_ready@%0d", i), rdy_log[i], (i == 10 || i == 20));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
